// File: rtl/rat_io_pkg.sv
// Shared RAT MCU I/O address map for the input mux and the output demux.
// Also holds the board I/O widths used by the input side.
package rat_io_pkg;

    localparam logic [7:0] SWITCHES_ID  = 8'h20;
    localparam logic [7:0] BUTTONS_ID   = 8'h24;
    localparam logic [7:0] BTN_EVENT_ID = 8'h25;
    localparam logic [7:0] LEDS_ID      = 8'h40;
    localparam logic [7:0] SEVSEG_ID    = 8'h81;

    localparam int NUM_SW  = 8;
    localparam int NUM_BTN = 4;

    function automatic logic [7:0] btn_word(input logic [NUM_BTN-1:0] b);
        return {{(8 - NUM_BTN){1'b0}}, b};
    endfunction

endpackage

// File: rtl/rat_debounce.sv
// Single-button debouncer: accepts a new level after DEBOUNCE_CYCLES stable cycles.
// RISE is combinational and marks the edge on which the level goes 0->1.
module rat_debounce #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic IN,
    output logic LEVEL,
    output logic RISE
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             accept;

    assign accept = (IN != level_q) && (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt     <= '0;
            level_q <= 1'b0;
        end else if (IN == level_q) begin
            cnt <= '0;
        end else if (accept) begin
            level_q <= IN;
            cnt     <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign LEVEL = level_q;
    assign RISE  = accept & IN;

endmodule

// File: rtl/rat_input_mux.sv
// RAT MCU input mux: switch sync, button debounce, sticky press events, IN read mux.
// Define RAT_BTN_IRQ_EN to build the button-press interrupt pulse on INTR.
module rat_input_mux #(
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PORT_ID_MCU,
    input  logic       IN_RD,
    input  logic [7:0] SWITCHES,
    input  logic [3:0] BUTTONS,
    output logic [7:0] IN_PORT,
    output logic       INTR
);

    import rat_io_pkg::*;

    logic [NUM_SW-1:0]  sw_s1;
    logic [NUM_SW-1:0]  sw_s2;
    logic [NUM_BTN-1:0] btn_s1;
    logic [NUM_BTN-1:0] btn_s2;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_BTN-1:0] evt_flags;
    logic               evt_clr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            sw_s1  <= SWITCHES;
            sw_s2  <= sw_s1;
            btn_s1 <= BUTTONS;
            btn_s2 <= btn_s1;
        end
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
        rat_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .CLK  (CLK),
            .RST_N(RST_N),
            .IN   (btn_s2[i]),
            .LEVEL(btn_level[i]),
            .RISE (btn_rise[i])
        );
    end

    assign evt_clr = IN_RD && (PORT_ID_MCU == BTN_EVENT_ID);

    // A rise on the clearing edge survives, so no press is lost to a read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            evt_flags <= '0;
        end else begin
            evt_flags <= (evt_flags & ~{NUM_BTN{evt_clr}}) | btn_rise;
        end
    end

    always_comb begin
        IN_PORT = 8'h00;
        case (PORT_ID_MCU)
            SWITCHES_ID:  IN_PORT = sw_s2;
            BUTTONS_ID:   IN_PORT = btn_word(btn_level);
            BTN_EVENT_ID: IN_PORT = btn_word(evt_flags);
            default:      IN_PORT = 8'h00;
        endcase
    end

`ifdef RAT_BTN_IRQ_EN
    logic intr_q;
    logic intr_d;

    // Newly set: was clear, or being cleared this cycle and re-set by a rise.
    assign intr_d = |(btn_rise & (~evt_flags | {NUM_BTN{evt_clr}}));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= intr_d;
        end
    end

    assign INTR = intr_q;
`else
    assign INTR = 1'b0;
`endif

endmodule
